// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready handshake feeding the boot-time program loader.
// The master drives bytes; the slave (loader) returns a registered ready.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into words,
// writes instruction memory and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      byte_in,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         asm_q, asm_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic        xfer;
    logic [7:0]  din;
    logic [15:0] n_full;

    assign xfer   = byte_in.in_valid & in_ready_q;
    assign din    = byte_in.in_data;
    assign n_full = {din, n_q[7:0]};

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            IDLE: begin
                state_d    = HDR0;
                in_ready_d = 1'b1;
                word_cnt_d = 16'd0;
                byte_cnt_d = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                xor_d      = 8'h00;
`endif
            end
            HDR0: begin
                if (xfer) begin
                    n_d[7:0] = din;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d    = CHK;
`else
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
`endif
                    end else if ({1'b0, n_full} > MAX_N) begin
                        state_d    = ERR;
                        in_ready_d = 1'b0;
                        err_d      = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // ready is only low in DATA during the final word's strobe cycle
                if (!in_ready_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d    = CHK;
                    in_ready_d = 1'b1;
`else
                    state_d    = DONE;
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
`endif
                end else if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ din;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = {din, asm_q};
                        im_addr_d  = ADDR_W'(BASE_ADDR + {14'd0, word_cnt_q, 2'b00});
                        word_cnt_d = word_cnt_q + 16'd1;
                        byte_cnt_d = 2'd0;
                        if (word_cnt_q == n_q - 16'd1) in_ready_d = 1'b0;
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    asm_d[7:0]   = din;
                            2'd1:    asm_d[15:8]  = din;
                            default: asm_d[23:16] = din;
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    in_ready_d = 1'b0;
                    if (din == xor_q) begin
                        state_d    = DONE;
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            DONE, ERR: begin
                if (start) begin
                    state_d    = HDR0;
                    in_ready_d = 1'b1;
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_cnt_d = 16'd0;
                    byte_cnt_d = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'h0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            n_q        <= 16'd0;
            word_cnt_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'h0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign byte_in.in_ready = in_ready_q;
    assign im_we            = im_we_q;
    assign im_addr          = im_addr_q;
    assign im_wdata         = im_wdata_q;
    assign core_rst         = core_rst_q;
    assign done             = done_q;
    assign err              = err_q;
endmodule
